// File: rtl/exec_pkg.sv
// Shared encodings for the multi-cycle execute stage: opcodes, ALU ops,
// exception codes written to $rstatus, and the mul/div sequencer states.
package exec_pkg;

  localparam logic [4:0] OPC_R    = 5'b00000;
  localparam logic [4:0] OPC_J    = 5'b00001;
  localparam logic [4:0] OPC_BNE  = 5'b00010;
  localparam logic [4:0] OPC_JAL  = 5'b00011;
  localparam logic [4:0] OPC_JR   = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_BLT  = 5'b00110;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;
  localparam logic [4:0] OPC_SETX = 5'b10101;
  localparam logic [4:0] OPC_BEX  = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide: one bit per cycle on operand magnitudes,
// followed by a single FIX cycle that restores the sign and flags overflow.
module multdiv_iter
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op_div,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] MAG_LIM = (2*WIDTH)'(1) << (WIDTH - 1);

  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic neg_q, neg_d;
  logic div_q, div_d;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // hi:lo is the running product (mul) or remainder:quotient (div)
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    neg_d    = neg_q;
    div_d    = div_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = op_div ? ST_DIV : ST_MUL;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = magnitude(a);
          m_d     = magnitude(b);
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
          div_d   = op_div;
        end
      end
      ST_MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      ST_DIV: begin
        if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = ST_FIX;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
    end
  end

  // Magnitude limit differs by sign: -2^(W-1) fits, +2^(W-1) does not.
  // MIN / -1 wraps back to MIN naturally through the negate.
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIX);
  assign prod   = {hi_q, lo_q};
  assign result = neg_q ? -$signed(lo_q) : $signed(lo_q);
  assign ovf    = done && !div_q && (neg_q ? (prod > MAG_LIM) : (prod >= MAG_LIM));

endmodule

// File: rtl/stage_execute_mc.sv
// Execute stage with operand bypass, single-cycle ALU, branch resolution and
// an iterative mul/div that stalls the front end through in_ready.
module stage_execute_mc
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit USE_MULDIV = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      insn,
  input  logic [WIDTH-1:0] regfile_operandA,
  input  logic [WIDTH-1:0] regfile_operandB,
  input  logic [WIDTH-1:0] pc_out,
  input  logic             mx_bypass_A,
  input  logic             wx_bypass_A,
  input  logic             mx_bypass_B,
  input  logic             wx_bypass_B,
  input  logic [WIDTH-1:0] o_xm_out,
  input  logic [WIDTH-1:0] data_writeReg,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] b_out,
  output logic [31:0]      insn_out,
  output logic             out_valid,
  output logic             write_exception,
  output logic             take_branch,
  output logic             j_took_branch,
  output logic [WIDTH-1:0] pc_in
);

  logic [4:0] opcode, alu_op, shamt;
  logic is_r, is_addi, is_mem, is_bex, is_j, is_jal, is_jr, is_bne, is_blt, is_setx;
  logic signed [WIDTH-1:0] op_a, op_b, alu_b, imm, sum, diff;
  logic [WIDTH-1:0] sc_res, j_target;
  logic sc_exc, issue, mdu_start, mdu_busy, mdu_done, mdu_ovf;
  logic signed [WIDTH-1:0] mdu_result;

  logic [WIDTH-1:0] o_out_q, o_out_d, b_out_q, b_out_d, pend_b_q, pend_b_d;
  logic [31:0] insn_out_q, insn_out_d, pend_insn_q, pend_insn_d;
  logic out_valid_q, out_valid_d, exc_q, exc_d;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] exc_word(input logic [2:0] code);
    return {{(WIDTH-3){1'b0}}, code};
  endfunction

  assign opcode  = insn_opcode(insn);
  assign shamt   = insn[11:7];
  assign is_r    = (opcode == OPC_R);
  assign is_addi = (opcode == OPC_ADDI);
  assign is_mem  = (opcode == OPC_SW) || (opcode == OPC_LW);
  assign is_bex  = (opcode == OPC_BEX);
  assign is_j    = (opcode == OPC_J);
  assign is_jal  = (opcode == OPC_JAL);
  assign is_jr   = (opcode == OPC_JR);
  assign is_bne  = (opcode == OPC_BNE);
  assign is_blt  = (opcode == OPC_BLT);
  assign is_setx = (opcode == OPC_SETX);

  // Bypass priority: MX beats WX beats the register file
  always_comb begin
    op_a = regfile_operandA;
    if (mx_bypass_A)      op_a = o_xm_out;
    else if (wx_bypass_A) op_a = data_writeReg;
    op_b = regfile_operandB;
    if (mx_bypass_B)      op_b = o_xm_out;
    else if (wx_bypass_B) op_b = data_writeReg;
  end

  assign imm      = {{(WIDTH-17){insn[16]}}, insn[16:0]};
  assign alu_b    = (is_addi || is_mem) ? imm : (is_bex ? '0 : op_b);
  assign alu_op   = is_r ? insn[6:2] : ALU_ADD;
  assign sum      = op_a + alu_b;
  assign diff     = op_a - alu_b;
  assign j_target = {pc_out[WIDTH-1:27], insn[26:0]};

  assign in_ready  = !mdu_busy;
  assign issue     = in_valid && in_ready;
  assign mdu_start = issue && is_r && USE_MULDIV &&
                     ((alu_op == ALU_MUL) || ((alu_op == ALU_DIV) && (op_b != '0)));

  always_comb begin
    sc_res = '0;
    sc_exc = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        sc_res = sum;
        if ((is_r || is_addi) && add_ovf(op_a, alu_b, sum)) begin
          sc_exc = 1'b1;
          sc_res = exc_word(is_addi ? EXC_ADDI : EXC_ADD);
        end
      end
      ALU_SUB: begin
        sc_res = diff;
        if (sub_ovf(op_a, alu_b, diff)) begin
          sc_exc = 1'b1;
          sc_res = exc_word(EXC_SUB);
        end
      end
      ALU_AND: sc_res = op_a & alu_b;
      ALU_OR:  sc_res = op_a | alu_b;
      ALU_SLL: sc_res = op_a << shamt;
      ALU_SRA: sc_res = op_a >>> shamt;
      ALU_DIV: begin
        if (USE_MULDIV && (alu_b == '0)) begin
          sc_exc = 1'b1;
          sc_res = exc_word(EXC_DIV);
        end
      end
      default: sc_res = '0;
    endcase
    if (is_jal) begin
      sc_res = pc_out;
      sc_exc = 1'b0;
    end else if (is_setx) begin
      sc_res = {{(WIDTH-27){1'b0}}, insn[26:0]};
      sc_exc = 1'b0;
    end
  end

  // Redirects only fire on the issue cycle
  always_comb begin
    take_branch   = 1'b0;
    j_took_branch = 1'b0;
    pc_in         = '0;
    if (issue) begin
      if ((is_bne && (op_a != op_b)) || (is_blt && (op_a > op_b))) begin
        take_branch = 1'b1;
        pc_in       = pc_out + imm;
      end else if (is_bex && (op_a != '0)) begin
        take_branch = 1'b1;
        pc_in       = j_target;
      end else if (is_j || is_jal) begin
        pc_in = j_target;
      end else if (is_jr) begin
        pc_in = op_b;
      end
      j_took_branch = take_branch || is_j || is_jal || is_jr;
    end
  end

  multdiv_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clock),
    .rst_n  (reset_n),
    .start  (mdu_start),
    .op_div (alu_op == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result),
    .ovf    (mdu_ovf)
  );

  // X/M register update: mul/div completion, single-cycle issue, or bubble
  always_comb begin
    o_out_d     = o_out_q;
    b_out_d     = b_out_q;
    insn_out_d  = insn_out_q;
    exc_d       = exc_q;
    out_valid_d = 1'b0;
    pend_insn_d = pend_insn_q;
    pend_b_d    = pend_b_q;
    if (mdu_done) begin
      o_out_d     = mdu_ovf ? exc_word(EXC_MUL) : mdu_result;
      exc_d       = mdu_ovf;
      b_out_d     = pend_b_q;
      insn_out_d  = pend_insn_q;
      out_valid_d = 1'b1;
    end else if (issue) begin
      if (mdu_start) begin
        pend_insn_d = insn;
        pend_b_d    = op_b;
      end else begin
        o_out_d     = sc_res;
        exc_d       = sc_exc;
        b_out_d     = op_b;
        insn_out_d  = insn;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_out_q     <= '0;
      b_out_q     <= '0;
      insn_out_q  <= '0;
      exc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      pend_insn_q <= '0;
      pend_b_q    <= '0;
    end else begin
      o_out_q     <= o_out_d;
      b_out_q     <= b_out_d;
      insn_out_q  <= insn_out_d;
      exc_q       <= exc_d;
      out_valid_q <= out_valid_d;
      pend_insn_q <= pend_insn_d;
      pend_b_q    <= pend_b_d;
    end
  end

  assign o_out           = o_out_q;
  assign b_out           = b_out_q;
  assign insn_out        = insn_out_q;
  assign out_valid       = out_valid_q;
  assign write_exception = exc_q;

endmodule

// File: doc/stage_execute_mc.md
Name: stage_execute_mc

Overview:
Next-generation execute stage, parametrised in datapath width. It sits between the D/X latch and the X/M latch and performs operand bypassing, single-cycle ALU ops, and branch/jump resolution. Unlike the single-cycle stage, it contains an iterative multiply/divide engine. It drives a valid/ready handshake that stalls the front end while mul/div is in flight, and all X/M-facing results are registered.

Parameters:
WIDTH, 32, datapath/PC width in bits; must be >= 32 (instruction fields fixed at 32 bits).
USE_MULDIV, 1, when 0 mul/div complete in one cycle with o_out=0, no exception, no stall.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  D/X holds a valid instruction
in_ready  out  1  stage can accept; high iff FSM in IDLE
insn  in  32  instruction from D/X
regfile_operandA  in  WIDTH  rs value from D/X
regfile_operandB  in  WIDTH  rt/rd value from D/X
pc_out  in  WIDTH  PC+1 of this instruction
mx_bypass_A, wx_bypass_A, mx_bypass_B, wx_bypass_B  in  1 each  bypass selects
o_xm_out  in  WIDTH  X/M result for bypass
data_writeReg  in  WIDTH  writeback data for bypass
o_out  out  WIDTH  registered result to X/M
b_out  out  WIDTH  registered bypassed B (store data)
insn_out  out  32  registered instruction to X/M
out_valid  out  1  registered; X/M contents valid this cycle
write_exception  out  1  registered; o_out holds exception code for $rstatus
take_branch  out  1  combinational; branch taken (issue cycle only)
j_took_branch  out  1  combinational; any PC redirect
pc_in  out  WIDTH  combinational redirect target

Behaviour:
- Reset (async, reset_n=0): FSM IDLE, counter 0, o_out/b_out/insn_out 0, out_valid 0, write_exception 0. Reset mid-mul/div aborts the op; no result is produced.
- Issue = in_valid & in_ready at a rising edge. Bypass priority per operand: MX > WX > regfile. Bypassed A/B are sampled at issue only.
- Operand B: immediate (sign-extended insn[16:0]) for addi/sw/lw; 0 for bex; else bypassed B.
- ALU op: insn[6:2] for R-type: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 00110 mul, 00111 div. Shamt is insn[11:7]. Opcode addi forces add.
- Single-cycle ops: o_out/b_out/insn_out/out_valid=1 registered at the issue edge (latency 1).
- Non-issue cycle in IDLE: out_valid<=0 (bubble); other registers hold.
- Exceptions: signed overflow on add/addi/sub, mul result not representable in WIDTH signed, or div by zero. Effect: write_exception=1 and o_out = 1 add, 2 addi, 3 sub, 4 mul, 5 div.
- jal: o_out=pc_out. setx: o_out = zero-extended insn[26:0].
- Branch (combinational, gated by in_valid & in_ready):
  - bne taken iff A!=B.
  - blt taken iff signed A > signed B.
  - bex taken iff A!=0.
  - j/jal/taken-bex: pc_in = {pc_out[WIDTH-1:27], insn[26:0]}.
  - taken bne/blt: pc_in = pc_out + sext(imm), WIDTH-bit wrap.
  - jr: pc_in = bypassed B.
  - Otherwise pc_in=0.
  - j_took_branch = any of the above redirects.
- Mul/div FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL/DIV on issue of mul/div. Magnitudes of A and B are captured and counter is set to 0. in_ready=0 from the next cycle, out_valid<=0.
  - MUL: shift-add, one bit per cycle. After WIDTH cycles -> FIX.
  - DIV: restoring, one quotient bit per cycle. After WIDTH cycles -> FIX.
  - FIX (1 cycle): apply sign, detect overflow, register o_out/insn_out/out_valid=1 -> IDLE.
  - in_ready is low for exactly WIDTH+1 cycles. out_valid rises WIDTH+1 edges after the issue edge.
- Div by zero: detected at issue. Completes as a single-cycle op with code 5; no stall.
- Div rounds toward zero. MIN / -1 = MIN with no exception.
- in_valid during the stall is ignored; upstream must hold.

Decomposition:
- Shared package exec_pkg:
  - opcode constants (R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110)
  - ALU-op constants
  - exception codes 1–5
  - FSM state enum
- One sub-module, multdiv_iter (parametrised WIDTH): start/op/operands in; done/result/ovf out. Holds the MUL/DIV/FIX datapath and counter.

Test Plan:
- add with mx_bypass_A=1, o_xm_out=7, B=5 -> next edge o_out=12, out_valid=1, in_ready stays 1.
- add 0x7FFFFFFF+1 -> o_out=1, write_exception=1; addi with same overflow -> o_out=2.
- mul -6*7, WIDTH=32 -> in_ready low 33 cycles, o_out=0xFFFFFFD6, out_valid pulses once. mul 0x10000*0x10000 -> o_out=4, write_exception=1.
- div -7/2 -> o_out=0xFFFFFFFD after 33 stall cycles. div 9/0 -> o_out=5, write_exception=1, no stall.
- blt A=5,B=3, pc_out=0x10, imm=-4 -> take_branch=1, pc_in=0x0C. bex A=0 -> take_branch=0. jr B=0x40 -> pc_in=0x40, j_took_branch=1.
- Assert reset_n=0 mid-div at cycle 10 -> in_ready=1 and out_valid=0 immediately. After release, add 1+1 -> o_out=2 next edge.
